// File: rtl/sm_acc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sm_acc_ctrl: sign-magnitude accumulator controller around an rca8 adder.  |
// | Optional saturation via SM_ACC_SAT_EN.                      Revision: 1.0 |
// +--------------------------------------------------------------------------+
module sm_acc_ctrl #(
   parameter logic [7:0] ACC_INIT = 8'h00,
   parameter int         COUNT_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         in_data,
   input  logic               in_op,
   input  logic               in_clr,
   output logic [7:0]         add_x,
   output logic [7:0]         add_y,
   output logic               add_cin,
   input  logic [7:0]         add_z,
   input  logic               add_cout,
   input  logic               add_ovr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [7:0]         out_acc,
   output logic               out_ovr,
   output logic               ovf_sticky,
   output logic [COUNT_W-1:0] op_cnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic [7:0]         acc;
   logic [7:0]         base_r;
   logic [7:0]         opnd_r;
   logic               ovr_r;
   logic               sticky_r;
   logic [COUNT_W-1:0] cnt_r;
   logic               accept;
   logic [7:0]         opnd_inv;
   logic [7:0]         opnd_norm;
   logic [7:0]         z_norm;
   logic [7:0]         acc_nxt;
   logic               unused_cout;

   assign unused_cout = add_cout;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (in_valid)  state_nxt = S_EXEC;
         S_EXEC:                 state_nxt = S_RESP;
         S_RESP:  if (out_ready) state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE:  in_ready  = 1'b1;
         S_RESP:  out_valid = 1'b1;
         default: ;
      endcase
   end

   assign accept    = in_valid && (state == S_IDLE);
   // Subtraction is addition of the sign-flipped operand; -0 must never reach the adder.
   assign opnd_inv  = {in_data[7] ^ in_op, in_data[6:0]};
   assign opnd_norm = (opnd_inv == 8'h80) ? 8'h00 : opnd_inv;
   assign z_norm    = (add_z == 8'h80) ? 8'h00 : add_z;

`ifdef SM_ACC_SAT_EN
   assign acc_nxt = add_ovr ? (base_r[7] ? 8'hFF : 8'h7F) : z_norm;
`else
   assign acc_nxt = z_norm;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc      <= ACC_INIT;
         base_r   <= ACC_INIT;
         opnd_r   <= 8'h00;
         ovr_r    <= 1'b0;
         sticky_r <= 1'b0;
         cnt_r    <= '0;
      end else if (accept) begin
         base_r <= in_clr ? ACC_INIT : acc;
         opnd_r <= opnd_norm;
         if (in_clr) begin
            sticky_r <= 1'b0;
            cnt_r    <= '0;
         end
      end else if (state == S_EXEC) begin
         acc      <= acc_nxt;
         ovr_r    <= add_ovr;
         sticky_r <= sticky_r | add_ovr;
         cnt_r    <= cnt_r + COUNT_W'(1);
      end
   end

   // Adder inputs come straight from registers so they cannot glitch.
   assign add_x      = base_r;
   assign add_y      = opnd_r;
   assign add_cin    = 1'b0;
   assign out_acc    = acc;
   assign out_ovr    = ovr_r;
   assign ovf_sticky = sticky_r;
   assign op_cnt     = cnt_r;

endmodule
`default_nettype wire
